if_adder_arbiter: RTL and testbench

//  Owns the single 16-bit adder in the IF stage and shares it between two requesters:

---
 rtl/if_adder_arbiter.sv | 104 ++++++++++
 tb/tb_if_adder_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_adder_arbiter.sv
// Shared IF-stage adder: arbitrates PC-increment (port 0) and branch-target (port 1)
// requests, latches the winner's operands, and returns a registered sum with a done strobe.
module if_adder_arbiter #(
   parameter int WIDTH   = 16,
   parameter bit RR_MODE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             ack0,
   output logic             done0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack1,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             owner;
   logic             ptr;       // port favoured on the next tie
   logic             grant_any;
   logic             grant_sel;

   // Handshake: a port holds req with stable operands until its ack pulse,
   // then drops req; its done pulse marks result/carry valid for that port.
   always_comb begin
      grant_any = req0 | req1;
      grant_sel = 1'b0;
      if (req0 && req1)
         grant_sel = RR_MODE ? ptr : 1'b0;
      else if (req1)
         grant_sel = 1'b1;
   end

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_a   <= '0;
         op_b   <= '0;
         owner  <= 1'b0;
         ptr    <= 1'b0;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         result <= '0;
         carry  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         ack0  <= 1'b0;
         ack1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  op_a  <= grant_sel ? a1 : a0;
                  op_b  <= grant_sel ? b1 : b0;
                  owner <= grant_sel;
                  ack0  <= ~grant_sel;
                  ack1  <= grant_sel;
                  busy  <= 1'b1;
                  state <= CALC;
                  // Only a contested grant moves the pointer.
                  if (req0 && req1)
                     ptr <= ~grant_sel;
               end
            end
            CALC: begin
               {carry, result} <= {1'b0, op_a} + {1'b0, op_b};
               done0 <= ~owner;
               done1 <= owner;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_adder_arbiter.sv
// Directed bench for if_adder_arbiter: round-robin and fixed-priority instances side by side.
module tb_if_adder_arbiter;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0, req1, ack0, ack1, done0, done1, carry, busy;
   logic [W-1:0] a0, b0, a1, b1, result;
   logic [1:0]   state_dbg;
   logic         f_req0, f_req1, f_ack0, f_ack1, f_done0, f_done1, f_carry, f_busy;
   logic [W-1:0] f_a0, f_b0, f_a1, f_b1, f_result;
   logic [1:0]   f_state_dbg;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic         port;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_sum;
      logic         exp_carry;
   } vec_t;

   vec_t vecs[5];

   if_adder_arbiter #(.WIDTH(W), .RR_MODE(1'b1)) u_rr (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0), .ack0(ack0), .done0(done0),
      .req1(req1), .a1(a1), .b1(b1), .ack1(ack1), .done1(done1),
      .result(result), .carry(carry), .busy(busy), .state_dbg(state_dbg)
   );

   if_adder_arbiter #(.WIDTH(W), .RR_MODE(1'b0)) u_fp (
      .clk(clk), .rst(rst),
      .req0(f_req0), .a0(f_a0), .b0(f_b0), .ack0(f_ack0), .done0(f_done0),
      .req1(f_req1), .a1(f_a1), .b1(f_b1), .ack1(f_ack1), .done1(f_done1),
      .result(f_result), .carry(f_carry), .busy(f_busy), .state_dbg(f_state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated request on the RR instance, checked cycle by cycle.
   task automatic run_single(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_sum, input logic exp_carry);
      if (port) begin a1 = a; b1 = b; req1 = 1'b1; end
      else      begin a0 = a; b0 = b; req0 = 1'b1; end
      tick();
      check("ack_own",   port ? ack1 : ack0, 1);
      check("ack_other", port ? ack0 : ack1, 0);
      check("busy_calc", busy, 1);
      check("state_calc", state_dbg, 1);
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      check("done_own",   port ? done1 : done0, 1);
      check("done_other", port ? done0 : done1, 0);
      check("ack_clear",  ack0 | ack1, 0);
      check("sum",   result, exp_sum);
      check("carry", carry, exp_carry);
      tick();
      check("done_clear", done0 | done1, 0);
      check("busy_idle",  busy, 0);
      repeat (2) tick();
      check("sum_hold",   result, exp_sum);
      check("carry_hold", carry, exp_carry);
   endtask

   initial begin
      int grants[$];
      int dones[$];
      int f_grants[$];
      int excl_bad;

      vecs[0] = '{1'b0, 16'd10,   16'd20,   16'd30,   1'b0};
      vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
      vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
      vecs[3] = '{1'b1, 16'h1234, 16'h4321, 16'h5555, 1'b0};
      vecs[4] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1};

      rst = 1'b1;
      {req0, req1, f_req0, f_req1} = '0;
      {a0, b0, a1, b1, f_a0, f_b0, f_a1, f_b1} = '0;
      repeat (2) tick();
      check("rst_ack",    {ack0, ack1, f_ack0, f_ack1}, 0);
      check("rst_done",   {done0, done1, f_done0, f_done1}, 0);
      check("rst_result", {result, f_result}, 0);
      check("rst_carry",  {carry, f_carry}, 0);
      check("rst_busy",   {busy, f_busy}, 0);
      check("rst_state",  {state_dbg, f_state_dbg}, 0);
      rst = 1'b0;
      tick();
      check("idle_noreq_busy", busy, 0);

      for (int i = 0; i < 5; i++)
         run_single(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_carry);

      // Both ports contend continuously: each drops req on ack, re-raises on done.
      excl_bad = 0;
      a0 = 16'd1; b0 = 16'd2; a1 = 16'd3; b1 = 16'd4;
      f_a0 = 16'd1; f_b0 = 16'd2; f_a1 = 16'd3; f_b1 = 16'd4;
      req0 = 1'b1; req1 = 1'b1; f_req0 = 1'b1; f_req1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if ((ack0 && ack1) || (done0 && done1) || ((ack0 || ack1) && (done0 || done1)))
            excl_bad++;
         if ((f_ack0 && f_ack1) || (f_done0 && f_done1) || ((f_ack0 || f_ack1) && (f_done0 || f_done1)))
            excl_bad++;
         if (ack0)    begin grants.push_back(0);   req0 = 1'b0;   end
         if (ack1)    begin grants.push_back(1);   req1 = 1'b0;   end
         if (done0)   begin dones.push_back(i);    req0 = 1'b1;   end
         if (done1)   begin dones.push_back(i);    req1 = 1'b1;   end
         if (f_ack0)  begin f_grants.push_back(0); f_req0 = 1'b0; end
         if (f_ack1)  begin f_grants.push_back(1); f_req1 = 1'b0; end
         if (f_done0) f_req0 = 1'b1;
         if (f_done1) f_req1 = 1'b1;
      end
      {req0, req1, f_req0, f_req1} = '0;
      repeat (4) tick();
      check("exclusive_strobes", excl_bad, 0);
      check("rr_grant_count", grants.size(), 4);
      for (int k = 0; k < 4; k++)
         check("rr_grant_order", (k < grants.size()) ? grants[k] : 99, k % 2);
      check("rr_done_count", dones.size(), 4);
      for (int k = 1; k < 4; k++)
         check("rr_done_spacing", (k < dones.size()) ? dones[k] - dones[k-1] : 99, 3);
      check("fp_grant_count", f_grants.size(), 4);
      for (int k = 0; k < 4; k++)
         check("fp_grant_port0", (k < f_grants.size()) ? f_grants[k] : 99, 0);

      // Reset during CALC aborts the operation.
      a0 = 16'd5; b0 = 16'd7; req0 = 1'b1;
      tick();
      check("abort_ack0", ack0, 1);
      req0 = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_done0",  done0, 0);
      check("abort_result", result, 0);
      check("abort_carry",  carry, 0);
      check("abort_busy",   busy, 0);
      tick();
      check("abort_no_late_done", done0 | done1, 0);
      run_single(1'b0, 16'd5, 16'd7, 16'd12, 1'b0);

      // Port 1 raised while port 0's add is in flight must wait for the next IDLE.
      a0 = 16'd3; b0 = 16'd4; req0 = 1'b1;
      tick();
      check("late_ack0", ack0, 1);
      req0 = 1'b0;
      a1 = 16'd100; b1 = 16'd1; req1 = 1'b1;
      tick();
      check("late_done0", done0, 1);
      check("late_sum0",  result, 7);
      check("late_ack1_calc", ack1, 0);
      tick();
      check("late_ack1_done", ack1, 0);
      check("late_idle_done_clear", done0 | done1, 0);
      tick();
      check("late_ack1", ack1, 1);
      req1 = 1'b0;
      tick();
      check("late_done1",     done1, 1);
      check("late_done0_off", done0, 0);
      check("late_sum1",      result, 101);
      check("late_carry1",    carry, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
